// File: rtl/watch_ui_pkg.sv
// watch_ui_pkg: shared mode codes, UI state encoding, per-mode last-field table
// and mode LED patterns for the watch UI sequencer.
package watch_ui_pkg;

    typedef enum logic [1:0] {
        MODE_TIME  = 2'd0,
        MODE_DATE  = 2'd1,
        MODE_ALARM = 2'd2,
        MODE_SW    = 2'd3
    } mode_e;

    typedef enum logic {
        ST_VIEW = 1'b0,
        ST_SET  = 1'b1
    } state_e;

    localparam logic [3:0] LED_TIME  = 4'b1000;
    localparam logic [3:0] LED_DATE  = 4'b0100;
    localparam logic [3:0] LED_ALARM = 4'b0010;
    localparam logic [3:0] LED_SW    = 4'b0001;

    // Index of the final editable field in each settable mode.
    function automatic logic [1:0] last_field(input mode_e m);
        logic [1:0] lf;
        case (m)
            MODE_TIME:  lf = 2'd1;   // hh, mm
            MODE_DATE:  lf = 2'd1;   // mm, dd
            MODE_ALARM: lf = 2'd2;   // hh, mm, enable
            default:    lf = 2'd0;
        endcase
        return lf;
    endfunction

    function automatic logic [3:0] mode_led_of(input mode_e m);
        logic [3:0] led;
        case (m)
            MODE_TIME:  led = LED_TIME;
            MODE_DATE:  led = LED_DATE;
            MODE_ALARM: led = LED_ALARM;
            default:    led = LED_SW;
        endcase
        return led;
    endfunction

endpackage

// File: rtl/btn_press_classifier.sv
// btn_press_classifier: turns a debounced button level into short/long press
// pulses. The hold counter advances on tick_1k while pressed and saturates at
// LONG_MS; a long event fires on the tick that reaches LONG_MS, a short event
// fires on the release cycle if the press never went long.
module btn_press_classifier #(
    parameter int unsigned LONG_MS = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_1k,
    input  logic btn,
    output logic short_ev,
    output logic long_ev,
    output logic held_long
);

    localparam int unsigned    CW       = $clog2(LONG_MS + 1);
    localparam logic [CW-1:0]  LONG_CNT = CW'(LONG_MS);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Hold counter: clears on release, saturates at LONG_MS while held.
    always_comb begin
        cnt_d = cnt_q;
        if (!btn) begin
            cnt_d = '0;
        end else if (tick_1k && (cnt_q != LONG_CNT)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Hold counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign long_ev   = btn && tick_1k && (cnt_q == (LONG_CNT - CW'(1)));
    assign short_ev  = !btn && (cnt_q != '0) && (cnt_q != LONG_CNT);
    assign held_long = btn && (cnt_q == LONG_CNT);

endmodule

// File: rtl/watch_ui_sequencer.sv
// watch_ui_sequencer: front-end controller for the four-mode watch. Classifies
// btn0/btn1 presses, owns the mode register and VIEW/SET state, and issues
// registered single-cycle command strobes plus stopwatch run/lap levels.
// Optional feature macro: AUTO_REPEAT_EN (btn1 held long in SET auto-repeats
// inc_stb every REPEAT_MS; without it a btn1 long press in SET is ignored).
module watch_ui_sequencer
    import watch_ui_pkg::*;
#(
    parameter int unsigned LONG_MS    = 1000,
    parameter int unsigned REPEAT_MS  = 200,
    parameter int unsigned TIMEOUT_MS = 10000,
    parameter int unsigned BLINK_MS   = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1k,
    input  logic       btn0,
    input  logic       btn1,
    output logic [1:0] mode,
    output logic [3:0] mode_led,
    output logic       setting,
    output logic [1:0] field,
    output logic       blink,
    output logic       inc_stb,
    output logic       commit_stb,
    output logic       cancel_stb,
    output logic       sw_run,
    output logic       sw_lap,
    output logic       sw_clr_stb
);

    localparam int unsigned   TW      = $clog2(TIMEOUT_MS + 1);
    localparam int unsigned   BW      = $clog2(BLINK_MS + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_MS - 1);
    localparam logic [BW-1:0] BL_LAST = BW'(BLINK_MS - 1);

    logic b0_short, b0_long, b0_held_long;
    logic b1_short, b1_long, b1_held_long;
    logic b0_ev, any_ev;

    btn_press_classifier #(.LONG_MS(LONG_MS)) u_cls_b0 (
        .clk       (clk),
        .rst       (rst),
        .tick_1k   (tick_1k),
        .btn       (btn0),
        .short_ev  (b0_short),
        .long_ev   (b0_long),
        .held_long (b0_held_long)
    );

    btn_press_classifier #(.LONG_MS(LONG_MS)) u_cls_b1 (
        .clk       (clk),
        .rst       (rst),
        .tick_1k   (tick_1k),
        .btn       (btn1),
        .short_ev  (b1_short),
        .long_ev   (b1_long),
        .held_long (b1_held_long)
    );

    assign b0_ev  = b0_short | b0_long;
    assign any_ev = b0_ev | b1_short | b1_long;

    state_e        state_q, state_d;
    mode_e         mode_q, mode_d;
    logic [3:0]    led_q, led_d;
    logic [1:0]    field_q, field_d;
    logic          blink_q, blink_d;
    logic [BW-1:0] bl_cnt_q, bl_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          inc_q, inc_d;
    logic          commit_q, commit_d;
    logic          cancel_q, cancel_d;
    logic          clr_q, clr_d;
    logic          run_q, run_d;
    logic          lap_q, lap_d;
    logic          rep_fire;

`ifdef AUTO_REPEAT_EN
    localparam int unsigned   RW      = $clog2(REPEAT_MS + 1);
    localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_MS - 1);

    logic          rep_act_q, rep_act_d;
    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          unused_cfg;

    assign unused_cfg = b0_held_long;
`else
    logic          unused_cfg;

    assign unused_cfg = b0_held_long ^ b1_held_long ^ (REPEAT_MS == 0);
`endif

    // Next-state logic: event arbitration (btn0 wins), mode/SET FSM, blink,
    // timeout and optional auto-repeat.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        field_d  = field_q;
        blink_d  = blink_q;
        bl_cnt_d = bl_cnt_q;
        to_cnt_d = to_cnt_q;
        inc_d    = 1'b0;
        commit_d = 1'b0;
        cancel_d = 1'b0;
        clr_d    = 1'b0;
        run_d    = run_q;
        lap_d    = lap_q;
        rep_fire = 1'b0;
`ifdef AUTO_REPEAT_EN
        rep_act_d = rep_act_q;
        rep_cnt_d = rep_cnt_q;
`endif

        case (state_q)
            ST_VIEW: begin
                if (b0_short) begin
                    mode_d = mode_e'(mode_q + 2'd1);
                end else if (b0_long) begin
                    if (mode_q == MODE_SW) begin
                        clr_d = 1'b1;
                        run_d = 1'b0;
                        lap_d = 1'b0;
                    end else begin
                        state_d  = ST_SET;
                        field_d  = '0;
                        blink_d  = 1'b0;
                        bl_cnt_d = '0;
                        to_cnt_d = '0;
                    end
                end else if (b1_short) begin
                    if (mode_q == MODE_SW) run_d = ~run_q;
                end else if (b1_long) begin
                    if (mode_q == MODE_SW) lap_d = ~lap_q;
                end
            end

            ST_SET: begin
                if (tick_1k) begin
                    if (bl_cnt_q == BL_LAST) begin
                        bl_cnt_d = '0;
                        blink_d  = ~blink_q;
                    end else begin
                        bl_cnt_d = bl_cnt_q + BW'(1);
                    end
                end

                if (any_ev) begin
                    to_cnt_d = '0;
                end else if (tick_1k) begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end

`ifdef AUTO_REPEAT_EN
                // Repeat runs off the saturated hold state so release simply ends it.
                if (rep_act_q) begin
                    if (!b1_held_long) begin
                        rep_act_d = 1'b0;
                    end else if (tick_1k) begin
                        if (rep_cnt_q == RP_LAST) begin
                            rep_cnt_d = '0;
                            inc_d     = 1'b1;
                            to_cnt_d  = '0;
                            rep_fire  = 1'b1;
                        end else begin
                            rep_cnt_d = rep_cnt_q + RW'(1);
                        end
                    end
                end
`endif

                if (b0_short) begin
                    if (field_q == last_field(mode_q)) begin
                        commit_d = 1'b1;
                        state_d  = ST_VIEW;
                    end else begin
                        field_d  = field_q + 2'd1;
                        blink_d  = 1'b0;
                        bl_cnt_d = '0;
                    end
                end else if (b0_long) begin
                    cancel_d = 1'b1;
                    state_d  = ST_VIEW;
                end else if (b1_short) begin
                    inc_d = 1'b1;
`ifdef AUTO_REPEAT_EN
                end else if (b1_long) begin
                    inc_d     = 1'b1;
                    rep_act_d = 1'b1;
                    rep_cnt_d = '0;
`endif
                end else if (!any_ev && !rep_fire && tick_1k && (to_cnt_q == TO_LAST)) begin
                    cancel_d = 1'b1;
                    state_d  = ST_VIEW;
                end
            end

            default: begin
                state_d = ST_VIEW;
            end
        endcase

        // Every path back to VIEW leaves the SET bookkeeping idle.
        if (state_d == ST_VIEW) begin
            field_d  = '0;
            blink_d  = 1'b0;
            bl_cnt_d = '0;
            to_cnt_d = '0;
`ifdef AUTO_REPEAT_EN
            rep_act_d = 1'b0;
            rep_cnt_d = '0;
`endif
        end

        led_d = mode_led_of(mode_d);
    end

    // FSM state, counters and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_VIEW;
            mode_q   <= MODE_TIME;
            led_q    <= LED_TIME;
            field_q  <= '0;
            blink_q  <= 1'b0;
            bl_cnt_q <= '0;
            to_cnt_q <= '0;
            inc_q    <= 1'b0;
            commit_q <= 1'b0;
            cancel_q <= 1'b0;
            clr_q    <= 1'b0;
            run_q    <= 1'b0;
            lap_q    <= 1'b0;
`ifdef AUTO_REPEAT_EN
            rep_act_q <= 1'b0;
            rep_cnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            led_q    <= led_d;
            field_q  <= field_d;
            blink_q  <= blink_d;
            bl_cnt_q <= bl_cnt_d;
            to_cnt_q <= to_cnt_d;
            inc_q    <= inc_d;
            commit_q <= commit_d;
            cancel_q <= cancel_d;
            clr_q    <= clr_d;
            run_q    <= run_d;
            lap_q    <= lap_d;
`ifdef AUTO_REPEAT_EN
            rep_act_q <= rep_act_d;
            rep_cnt_q <= rep_cnt_d;
`endif
        end
    end

    assign mode       = mode_q;
    assign mode_led   = led_q;
    assign setting    = (state_q == ST_SET);
    assign field      = field_q;
    assign blink      = blink_q;
    assign inc_stb    = inc_q;
    assign commit_stb = commit_q;
    assign cancel_stb = cancel_q;
    assign sw_run     = run_q;
    assign sw_lap     = lap_q;
    assign sw_clr_stb = clr_q;

endmodule

// File: tb/tb_watch_ui_sequencer.sv
// tb_watch_ui_sequencer: directed stimulus with a scoreboard of expected
// output snapshots; the monitor pops one entry whenever a strobe fires or a
// visible output level changes. LONG=10, REPEAT=4, TIMEOUT=50, BLINK=3 ticks.
module tb_watch_ui_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_1k = 1'b0;
    logic       btn0 = 1'b0;
    logic       btn1 = 1'b0;
    logic [1:0] mode;
    logic [3:0] mode_led;
    logic       setting;
    logic [1:0] field;
    logic       blink;
    logic       inc_stb, commit_stb, cancel_stb, sw_run, sw_lap, sw_clr_stb;

    // {mode, led, setting, field, run, lap, inc, commit, cancel, clr}
    typedef struct packed {
        logic [1:0] mode;
        logic [3:0] led;
        logic       setting;
        logic [1:0] field;
        logic       run;
        logic       lap;
        logic       inc;
        logic       commit;
        logic       cancel;
        logic       clr;
    } snap_t;

    snap_t exp_q[$];
    string name_q[$];
    int    n_assert = 0;
    int    n_fail   = 0;
    logic  mon_en   = 1'b0;

    watch_ui_sequencer #(
        .LONG_MS    (10),
        .REPEAT_MS  (4),
        .TIMEOUT_MS (50),
        .BLINK_MS   (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_1k    (tick_1k),
        .btn0       (btn0),
        .btn1       (btn1),
        .mode       (mode),
        .mode_led   (mode_led),
        .setting    (setting),
        .field      (field),
        .blink      (blink),
        .inc_stb    (inc_stb),
        .commit_stb (commit_stb),
        .cancel_stb (cancel_stb),
        .sw_run     (sw_run),
        .sw_lap     (sw_lap),
        .sw_clr_stb (sw_clr_stb)
    );

    always #5 clk = ~clk;

    // 1 kHz enable: one cycle high out of every four.
    initial begin
        forever begin
            repeat (3) @(negedge clk);
            tick_1k = 1'b1;
            @(negedge clk);
            tick_1k = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual still running required finished");
        $fatal(1, "watchdog expired");
    end

    function automatic snap_t cur_snap();
        snap_t s;
        s = {mode, mode_led, setting, field, sw_run, sw_lap,
             inc_stb, commit_stb, cancel_stb, sw_clr_stb};
        return s;
    endfunction

    task automatic push(input string nm, input logic [1:0] m, input logic [3:0] led,
                        input logic st, input logic [1:0] f, input logic run, input logic lap,
                        input logic inc, input logic com, input logic can, input logic clr);
        snap_t s;
        s = {m, led, st, f, run, lap, inc, com, can, clr};
        exp_q.push_back(s);
        name_q.push_back(nm);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_assert++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, req);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            do @(posedge clk); while (tick_1k !== 1'b1);
        end
    endtask

    // which: 0 = btn0, 1 = btn1, 2 = both (pressed and released together)
    task automatic press(input int which, input int n);
        @(negedge clk);
        if (which != 1) btn0 = 1'b1;
        if (which != 0) btn1 = 1'b1;
        wait_ticks(n);
        @(negedge clk);
        btn0 = 1'b0;
        btn1 = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    // Monitor: compare against the scoreboard on every visible output event.
    initial begin
        snap_t      s, e;
        string      nm;
        logic [10:0] prev;
        wait (mon_en);
        s    = cur_snap();
        prev = s[14:4];
        forever begin
            @(negedge clk);
            s = cur_snap();
            if ((s[3:0] != 4'b0000) || (s[14:4] != prev)) begin
                n_assert++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output: actual %b required no event", s);
                end else begin
                    e  = exp_q.pop_front();
                    nm = name_q.pop_front();
                    if (s !== e) begin
                        n_fail++;
                        $display("FAIL %s: actual %b required %b", nm, s, e);
                    end
                end
            end
            prev = s[14:4];
        end
    end

    initial begin
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_state",
              {mode, mode_led, setting, field, blink, sw_run, sw_lap,
               inc_stb, commit_stb, cancel_stb, sw_clr_stb},
              {2'd0, 4'b1000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000});
        mon_en = 1'b1;
        @(negedge clk);

        // 1: four short btn0 presses walk the modes
        push("t1_mode1", 2'd1, 4'b0100, 0, 2'd0, 0, 0, 0, 0, 0, 0); press(0, 3);
        push("t1_mode2", 2'd2, 4'b0010, 0, 2'd0, 0, 0, 0, 0, 0, 0); press(0, 3);
        push("t1_mode3", 2'd3, 4'b0001, 0, 2'd0, 0, 0, 0, 0, 0, 0); press(0, 3);
        push("t1_mode0", 2'd0, 4'b1000, 0, 2'd0, 0, 0, 0, 0, 0, 0); press(0, 3);

        // 2: alarm SET walks three fields then commits
        push("t2_mode1", 2'd1, 4'b0100, 0, 2'd0, 0, 0, 0, 0, 0, 0); press(0, 3);
        push("t2_mode2", 2'd2, 4'b0010, 0, 2'd0, 0, 0, 0, 0, 0, 0); press(0, 3);
        push("t2_set",   2'd2, 4'b0010, 1, 2'd0, 0, 0, 0, 0, 0, 0); press(0, 12);
        push("t2_f1",    2'd2, 4'b0010, 1, 2'd1, 0, 0, 0, 0, 0, 0); press(0, 3);
        push("t2_f2",    2'd2, 4'b0010, 1, 2'd2, 0, 0, 0, 0, 0, 0); press(0, 3);
        push("t2_commit",2'd2, 4'b0010, 0, 2'd0, 0, 0, 0, 1, 0, 0); press(0, 3);

        // 3: stopwatch run, lap, clear
        push("t3_mode3", 2'd3, 4'b0001, 0, 2'd0, 0, 0, 0, 0, 0, 0); press(0, 3);
        push("t3_run",   2'd3, 4'b0001, 0, 2'd0, 1, 0, 0, 0, 0, 0); press(1, 3);
        push("t3_lap",   2'd3, 4'b0001, 0, 2'd0, 1, 1, 0, 0, 0, 0); press(1, 12);
        push("t3_clr",   2'd3, 4'b0001, 0, 2'd0, 0, 0, 0, 0, 0, 1); press(0, 12);

        // 4: time SET left idle -> blink cadence, then timeout cancel at tick 50
        push("t4_mode0", 2'd0, 4'b1000, 0, 2'd0, 0, 0, 0, 0, 0, 0); press(0, 3);
        push("t4_set",   2'd0, 4'b1000, 1, 2'd0, 0, 0, 0, 0, 0, 0);
        push("t4_cancel",2'd0, 4'b1000, 0, 2'd0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        btn0 = 1'b1;
        wait_ticks(10);
        @(negedge clk);
        btn0 = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            wait_ticks(1);
            #1;
            if (k <= 12) check($sformatf("t4_blink_k%0d", k), {31'd0, blink}, (k / 3) % 2);
            if (k == 49) check("t4_before_timeout", {31'd0, setting}, 32'd1);
            if (k == 50) check("t4_timeout", {29'd0, setting, cancel_stb, field}, {29'd0, 1'b0, 1'b1, 2'd0});
        end
        repeat (8) @(negedge clk);

        // 5: btn1 held 22 ticks in SET
        push("t5_set",   2'd0, 4'b1000, 1, 2'd0, 0, 0, 0, 0, 0, 0); press(0, 10);
`ifdef AUTO_REPEAT_EN
        push("t5_inc_long", 2'd0, 4'b1000, 1, 2'd0, 0, 0, 1, 0, 0, 0);
        push("t5_rep1",     2'd0, 4'b1000, 1, 2'd0, 0, 0, 1, 0, 0, 0);
        push("t5_rep2",     2'd0, 4'b1000, 1, 2'd0, 0, 0, 1, 0, 0, 0);
        push("t5_rep3",     2'd0, 4'b1000, 1, 2'd0, 0, 0, 1, 0, 0, 0);
`endif
        press(1, 22);
        push("t5_cancel",2'd0, 4'b1000, 0, 2'd0, 0, 0, 0, 0, 1, 0); press(0, 12);

        // 6: inc, simultaneous release, reset mid-SET and mid-press
        push("t6_set",   2'd0, 4'b1000, 1, 2'd0, 0, 0, 0, 0, 0, 0); press(0, 10);
        push("t6_inc",   2'd0, 4'b1000, 1, 2'd0, 0, 0, 1, 0, 0, 0); press(1, 3);
        push("t6_both",  2'd0, 4'b1000, 1, 2'd1, 0, 0, 0, 0, 0, 0); press(2, 3);
        @(negedge clk);
        btn0 = 1'b1;
        wait_ticks(5);
        push("t6_rst",   2'd0, 4'b1000, 0, 2'd0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_state", {23'd0, mode, mode_led, setting, field, blink},
              {23'd0, 2'd0, 4'b1000, 1'b0, 2'd0, 1'b0});
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        push("t6_repress", 2'd1, 4'b0100, 0, 2'd0, 0, 0, 0, 0, 0, 0);
        wait_ticks(7);
        @(negedge clk);
        btn0 = 1'b0;
        repeat (12) @(negedge clk);

        check("pending_expectations", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
